// File: rtl/kmeans_pkg.sv
// kmeans_pkg: shared K-means sizes, accumulator FSM states and one-hot helper
package kmeans_pkg;
  localparam int NCORE = 16;
  localparam int COORD_W = 10;
  localparam int CNT_W = 16;
  localparam int SUM_W = COORD_W + CNT_W;
  localparam int IDX_W = $clog2(NCORE);
  typedef enum logic [2:0] {IDLE, LOAD, DIV_X, DIV_Y, EMIT, FIN} state_t;
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [NCORE-1:0] v);
    lowest_idx = '0;
    for (int i = NCORE - 1; i >= 0; i--) if (v[i]) lowest_idx = IDX_W'(i);
  endfunction
endpackage

// File: rtl/cluster_accumulator_if.sv
// cluster_accumulator_if: point input handshake and centroid output bus
interface cluster_accumulator_if #(parameter int COORD_W = kmeans_pkg::COORD_W);
  import kmeans_pkg::*;
  logic pt_valid, pt_ready;
  logic [COORD_W-1:0] pt_x, pt_y;
  logic [NCORE-1:0] pt_core;
  logic cent_valid, cent_empty;
  logic [IDX_W-1:0] cent_idx;
  logic [COORD_W-1:0] cent_x, cent_y;
  modport master (output pt_valid, pt_x, pt_y, pt_core,
                  input pt_ready, cent_valid, cent_idx, cent_x, cent_y, cent_empty);
  modport slave (input pt_valid, pt_x, pt_y, pt_core,
                 output pt_ready, cent_valid, cent_idx, cent_x, cent_y, cent_empty);
endinterface

// File: rtl/serial_divider.sv
// serial_divider: restoring unsigned divider, done pulses exactly SUM_W cycles after start
module serial_divider #(
  parameter int SUM_W = kmeans_pkg::SUM_W,
  parameter int CNT_W = kmeans_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SUM_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic             done,
  output logic [SUM_W-1:0] quotient
);
  localparam int NW = $clog2(SUM_W + 1);
  logic [CNT_W-1:0] rem, dvs, d;
  logic [SUM_W-1:0] q;
  logic [CNT_W:0] t, diff;
  logic [NW-1:0] n;
  // the start cycle performs the first iteration on the fresh operands
  always_comb begin
    d = start ? divisor : dvs;
    q = start ? dividend : quotient;
    t = {rem & {CNT_W{!start}}, q[SUM_W-1]};
    diff = t - {1'b0, d};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rem <= '0;
      dvs <= '0;
      quotient <= '0;
      n <= '0;
      done <= 1'b0;
    end else begin
      done <= !start && n == NW'(1);
      if (start || n != '0) begin
        rem <= diff[CNT_W] ? t[CNT_W-1:0] : diff[CNT_W-1:0];
        quotient <= {q[SUM_W-2:0], !diff[CNT_W]};
        dvs <= d;
        n <= start ? NW'(SUM_W - 1) : n - 1'b1;
      end
    end
endmodule

// File: rtl/cluster_accumulator.sv
// cluster_accumulator: per-cluster sums/counts, then serial floor-mean centroid walk over 16 clusters
module cluster_accumulator #(
  parameter int COORD_W = kmeans_pkg::COORD_W,
  parameter int CNT_W = kmeans_pkg::CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic upd_start,
  cluster_accumulator_if.slave bus,
  output logic busy,
  output logic done,
  output logic ovf
);
  localparam int SUM_W = COORD_W + CNT_W;
  import kmeans_pkg::*;
  state_t state;
  logic [IDX_W-1:0] idx, k;
  logic [SUM_W-1:0] sum_x [NCORE];
  logic [SUM_W-1:0] sum_y [NCORE];
  logic [CNT_W-1:0] cnt [NCORE];
  logic dv_start, dv_done;
  logic [SUM_W-1:0] dv_q;
  assign k = lowest_idx(bus.pt_core);
  assign bus.pt_ready = rst_n && state == IDLE && !clear;
  assign dv_start = (state == LOAD && cnt[idx] != '0) || (state == DIV_X && dv_done);
  serial_divider #(.SUM_W(SUM_W), .CNT_W(CNT_W)) u_div (
    .clk(clk),
    .rst_n(rst_n),
    .start(dv_start),
    .dividend(state == LOAD ? sum_x[idx] : sum_y[idx]),
    .divisor(cnt[idx]),
    .done(dv_done),
    .quotient(dv_q)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      ovf <= 1'b0;
      bus.cent_valid <= 1'b0;
      bus.cent_idx <= '0;
      bus.cent_x <= '0;
      bus.cent_y <= '0;
      bus.cent_empty <= 1'b0;
      for (int i = 0; i < NCORE; i++) begin
        sum_x[i] <= '0;
        sum_y[i] <= '0;
        cnt[i] <= '0;
      end
    end else begin
      bus.cent_valid <= 1'b0;
      done <= 1'b0;
      if (clear || state == FIN) begin
        for (int i = 0; i < NCORE; i++) begin
          sum_x[i] <= '0;
          sum_y[i] <= '0;
          cnt[i] <= '0;
        end
        state <= IDLE;
        busy <= 1'b0;
        ovf <= ovf & ~clear;
      end else case (state)
        IDLE: begin
          if (bus.pt_valid && |bus.pt_core) begin
            if (&cnt[k]) ovf <= 1'b1;
            else begin
              sum_x[k] <= sum_x[k] + SUM_W'(bus.pt_x);
              sum_y[k] <= sum_y[k] + SUM_W'(bus.pt_y);
              cnt[k] <= cnt[k] + 1'b1;
            end
          end
          if (upd_start) begin
            state <= LOAD;
            idx <= '0;
            busy <= 1'b1;
          end
        end
        LOAD:
          if (cnt[idx] == '0) begin
            state <= EMIT;
            bus.cent_valid <= 1'b1;
            bus.cent_idx <= idx;
            bus.cent_x <= '0;
            bus.cent_y <= '0;
            bus.cent_empty <= 1'b1;
          end else state <= DIV_X;
        DIV_X:
          if (dv_done) begin
            bus.cent_x <= dv_q[COORD_W-1:0];
            state <= DIV_Y;
          end
        DIV_Y:
          if (dv_done) begin
            bus.cent_y <= dv_q[COORD_W-1:0];
            bus.cent_empty <= 1'b0;
            bus.cent_idx <= idx;
            bus.cent_valid <= 1'b1;
            state <= EMIT;
          end
        EMIT:
          if (idx == IDX_W'(NCORE - 1)) begin
            state <= FIN;
            done <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
            state <= LOAD;
          end
        default: state <= IDLE;
      endcase
    end
  // a mean never exceeds the largest coordinate, so the quotient's high bits stay clear
  assert property (@(posedge clk) disable iff (!rst_n) dv_done |-> dv_q[SUM_W-1:COORD_W] == '0);
endmodule

// File: tb/tb_cluster_accumulator.sv
// tb_cluster_accumulator: directed vectors on a default build and a CNT_W=2 build
module tb_cluster_accumulator;
  typedef struct { logic [9:0] x, y; logic [15:0] core; } pt_t;
  typedef struct { logic e; logic [9:0] x, y; } cen_t;
  logic clk = 0, rst_n = 0, clear = 0, upd_start = 0, pt_valid = 0, sel = 0;
  logic [9:0] pt_x = 0, pt_y = 0;
  logic [15:0] pt_core = 0;
  logic busy0, done0, ovf0, busy2, done2, ovf2;
  logic cv, dn, ce, bz, ov, rdy;
  logic [3:0] ci;
  logic [9:0] cx, cy;
  int tests = 0, fails = 0;
  int rcount, first, done_at, order_err, overlap;
  logic [9:0] rx [16];
  logic [9:0] ry [16];
  logic re [16];
  pt_t pts [10];
  cen_t exp_c [16];

  always #5 clk = ~clk;

  cluster_accumulator_if b0 ();
  cluster_accumulator_if b2 ();
  assign b0.pt_valid = pt_valid;
  assign b0.pt_x = pt_x;
  assign b0.pt_y = pt_y;
  assign b0.pt_core = pt_core;
  assign b2.pt_valid = pt_valid;
  assign b2.pt_x = pt_x;
  assign b2.pt_y = pt_y;
  assign b2.pt_core = pt_core;

  cluster_accumulator u0 (.clk(clk), .rst_n(rst_n), .clear(clear), .upd_start(upd_start),
                          .bus(b0.slave), .busy(busy0), .done(done0), .ovf(ovf0));
  cluster_accumulator #(.CNT_W(2)) u2 (.clk(clk), .rst_n(rst_n), .clear(clear), .upd_start(upd_start),
                                       .bus(b2.slave), .busy(busy2), .done(done2), .ovf(ovf2));

  always_comb begin
    cv = sel ? b2.cent_valid : b0.cent_valid;
    dn = sel ? done2 : done0;
    ce = sel ? b2.cent_empty : b0.cent_empty;
    bz = sel ? busy2 : busy0;
    ov = sel ? ovf2 : ovf0;
    rdy = sel ? b2.pt_ready : b0.pt_ready;
    ci = sel ? b2.cent_idx : b0.cent_idx;
    cx = sel ? b2.cent_x : b0.cent_x;
    cy = sel ? b2.cent_y : b0.cent_y;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pt(input logic [9:0] x, input logic [9:0] y, input logic [15:0] core);
    pt_x = x;
    pt_y = y;
    pt_core = core;
    pt_valid = 1;
    step();
    pt_valid = 0;
  endtask

  task automatic set_empty();
    for (int i = 0; i < 16; i++) exp_c[i] = '{1'b1, 10'd0, 10'd0};
  endtask

  task automatic run_upd(input bit hold);
    rcount = 0;
    first = -1;
    done_at = -1;
    order_err = 0;
    overlap = 0;
    for (int i = 0; i < 16; i++) begin
      rx[i] = '1;
      ry[i] = '1;
      re[i] = 0;
    end
    upd_start = 1;
    for (int c = 1; c <= 1200 && done_at < 0; c++) begin
      step();
      if (c == 1) begin
        upd_start = hold;
        pt_valid = hold;
        pt_x = 9;
        pt_y = 9;
        pt_core = 16'h0002;
      end
      if (c == 10 && hold) chk("busy_ready_while_busy", {30'd0, bz, rdy}, 32'd2);
      if (c == 20) begin
        upd_start = 0;
        pt_valid = 0;
      end
      if (cv) begin
        if (first < 0) first = c;
        if (int'(ci) != rcount) order_err++;
        rx[ci] = cx;
        ry[ci] = cy;
        re[ci] = ce;
        rcount++;
      end
      if (dn) begin
        done_at = c;
        overlap += int'(cv);
      end
    end
    chk("done_seen", {31'd0, done_at > 0}, 32'd1);
    step();
    chk("busy_after_done", {31'd0, bz}, 32'd0);
  endtask

  task automatic chk_results(input string tag, input int exp_first, input int exp_done);
    chk({tag, " count"}, rcount, 16);
    chk({tag, " order"}, order_err, 0);
    chk({tag, " valid_done_overlap"}, overlap, 0);
    chk({tag, " first_latency"}, first, exp_first);
    chk({tag, " done_cycle"}, done_at, exp_done);
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s c%0d", tag, i), {11'd0, re[i], rx[i], ry[i]},
          {11'd0, exp_c[i].e, exp_c[i].x, exp_c[i].y});
  endtask

  initial begin
    int n_ev;
    pts[0] = '{10'd10, 10'd20, 16'h0001};
    pts[1] = '{10'd13, 10'd25, 16'h0001};
    pts[2] = '{10'd5, 10'd5, 16'h0000};
    pts[3] = '{10'd7, 10'd9, 16'h0030};
    pts[4] = '{10'd1023, 10'd1023, 16'h8000};
    pts[5] = '{10'd1000, 10'd0, 16'h8000};
    pts[6] = '{10'd0, 10'd1, 16'h0400};
    pts[7] = '{10'd3, 10'd2, 16'h0400};
    pts[8] = '{10'd4, 10'd4, 16'h0400};
    pts[9] = '{10'd100, 10'd200, 16'hFFF8};

    #12;
    chk("reset_outputs_d0", {busy0, done0, ovf0, b0.pt_ready, b0.cent_valid, b0.cent_empty,
                             b0.cent_idx, b0.cent_x, b0.cent_y}, 0);
    chk("reset_outputs_d2", {busy2, done2, ovf2, b2.pt_ready, b2.cent_valid, b2.cent_empty,
                             b2.cent_idx, b2.cent_x, b2.cent_y}, 0);
    rst_n = 1;
    step();
    chk("ready_after_reset", {31'd0, rdy}, 32'd1);
    send_pt(10, 10, 16'h0001);
    send_pt(20, 20, 16'h0002);
    upd_start = 1;
    step();
    upd_start = 0;
    step();
    step();
    chk("busy_before_reset", {30'd0, busy0, busy2}, 32'd3);
    #3 rst_n = 0;
    #1;
    chk("reset_mid_d0", {busy0, done0, ovf0, b0.pt_ready, b0.cent_valid, b0.cent_empty,
                         b0.cent_idx, b0.cent_x, b0.cent_y}, 0);
    chk("reset_mid_d2", {busy2, done2, ovf2, b2.pt_ready, b2.cent_valid, b2.cent_empty,
                         b2.cent_idx, b2.cent_x, b2.cent_y}, 0);
    #3 rst_n = 1;
    step();
    run_upd(0);
    set_empty();
    chk_results("empty_after_reset", 2, 33);

    for (int i = 0; i < 9; i++) send_pt(pts[i].x, pts[i].y, pts[i].core);
    pt_x = pts[9].x;
    pt_y = pts[9].y;
    pt_core = pts[9].core;
    pt_valid = 1;
    run_upd(1);
    set_empty();
    exp_c[0] = '{1'b0, 10'd11, 10'd22};
    exp_c[3] = '{1'b0, 10'd100, 10'd200};
    exp_c[4] = '{1'b0, 10'd7, 10'd9};
    exp_c[10] = '{1'b0, 10'd2, 10'd2};
    exp_c[15] = '{1'b0, 10'd1011, 10'd511};
    chk_results("batch", 54, 293);

    run_upd(0);
    set_empty();
    chk_results("cleared_by_fin", 2, 33);

    send_pt(50, 60, 16'h0001);
    upd_start = 1;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 1) upd_start = 0;
    end
    clear = 1;
    step();
    clear = 0;
    chk("busy_after_abort", {31'd0, bz}, 32'd0);
    n_ev = 0;
    for (int c = 0; c < 100; c++) begin
      step();
      n_ev += int'(cv) + int'(dn);
    end
    chk("no_emit_after_abort", n_ev, 0);
    run_upd(0);
    set_empty();
    chk_results("after_abort", 2, 33);

    sel = 1;
    for (int i = 0; i < 3; i++) send_pt(100, 100, 16'h0004);
    chk("ovf_before_sat", {31'd0, ov}, 32'd0);
    send_pt(100, 100, 16'h0004);
    chk("ovf_set", {31'd0, ov}, 32'd1);
    run_upd(0);
    set_empty();
    exp_c[2] = '{1'b0, 10'd100, 10'd100};
    chk_results("saturate", 2, 57);
    chk("ovf_survives_done", {31'd0, ov}, 32'd1);
    clear = 1;
    pt_x = 10;
    pt_y = 10;
    pt_core = 16'h0001;
    pt_valid = 1;
    #1;
    chk("ready_during_clear", {31'd0, rdy}, 32'd0);
    step();
    clear = 0;
    pt_valid = 0;
    chk("ovf_cleared", {31'd0, ov}, 32'd0);
    run_upd(0);
    set_empty();
    chk_results("after_idle_clear", 2, 33);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
